// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and holds busy for a fixed latency.
// Optional MD_CANCEL_EN adds md_cancel to abort an operation or suppress a start on a flush.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
`ifdef MD_CANCEL_EN
   input  logic        md_cancel,
`endif
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [3:0] MULT_N  = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N   = 4'(DIV_CYCLES);

   logic [0:0]  r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_op;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic        w_cancel;

`ifdef MD_CANCEL_EN
   assign w_cancel = md_cancel;
`else
   assign w_cancel = 1'b0;
`endif

   // Result is a pure function of the latched operands; it is committed on the completion edge.
   logic [63:0] w_prod_s, w_prod_u;
   logic        w_div_sgn, w_neg_a, w_neg_b;
   logic [31:0] w_mag_a, w_mag_b, w_uq, w_ur, w_q, w_r;
   logic [31:0] w_res_hi, w_res_lo;

   assign w_prod_s  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u  = {32'b0, r_a} * {32'b0, r_b};

   // Signed divide runs on magnitudes, so 0x80000000 / -1 lands on 0x80000000 rem 0 naturally.
   assign w_div_sgn = (r_op == 2'b10);
   assign w_neg_a   = w_div_sgn & r_a[31];
   assign w_neg_b   = w_div_sgn & r_b[31];
   assign w_mag_a   = w_neg_a ? (32'd0 - r_a) : r_a;
   assign w_mag_b   = w_neg_b ? (32'd0 - r_b) : r_b;
   assign w_uq      = w_mag_a / w_mag_b;
   assign w_ur      = w_mag_a % w_mag_b;
   assign w_q       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
   assign w_r       = w_neg_a ? (32'd0 - w_ur) : w_ur;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      case (r_op)
         2'b00:   {w_res_hi, w_res_lo} = w_prod_s;
         2'b01:   {w_res_hi, w_res_lo} = w_prod_u;
         default: begin
            if (r_b == 32'd0) begin
               w_res_hi = r_a;
               w_res_lo = 32'hFFFF_FFFF;
            end else begin
               w_res_hi = w_r;
               w_res_lo = w_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_op    <= 2'b00;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !w_cancel) begin
                  case (md_op)
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        r_op    <= md_op[1:0];
                        r_a     <= rs_val;
                        r_b     <= rt_val;
                        r_cnt   <= md_op[1] ? DIV_N : MULT_N;
                        r_state <= ST_RUN;
                     end
                     3'b100:  r_hi <= rs_val;
                     3'b101:  r_lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            default: begin
               if (w_cancel) begin
                  r_cnt   <= 4'd0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd1) begin
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
                  r_cnt   <= 4'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt   <= r_cnt - 4'd1;
               end
            end
         endcase
      end
   end

   assign busy = (r_state == ST_RUN);
   assign hi   = r_hi;
   assign lo   = r_lo;

   // The hazard unit must keep start low while busy; such a start is dropped.
   always @(posedge clk) begin
      if (!reset)
         assert (!(start && busy)) else $warning("md_sequencer: start while busy dropped");
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against a high-level arithmetic model.
module tb_md_sequencer;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'b000;
   logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
   logic        md_cancel = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk),
      .reset(reset),
`ifdef MD_CANCEL_EN
      .md_cancel(md_cancel),
`endif
      .start(start),
      .md_op(md_op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .busy(busy),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;

   // Expected {hi, lo} from the architectural definition using 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'b000: begin q = sa * sb; p = q; return p; end
         3'b001: begin p = 64'(a) * 64'(b); return p; end
         3'b010: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op);
      return op[1] ? DIV_N : MULT_N;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op and waits for busy to fall; reports busy length and whether hi/lo held still.
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit stable);
      logic [31:0] h0, l0;
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      tick();
      start = 1'b0;
      h0 = hi; l0 = lo;
      cycles = 0;
      stable = 1'b1;
      while (busy && cycles < 40) begin
         cycles++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         tick();
      end
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      start = 1'b1; md_op = op; rs_val = v; rt_val = 32'd0;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
   endtask

   task automatic test_mult();
      int cyc; bit st; logic [63:0] e; logic [2:0] op; logic [31:0] a, b;
      run_md(3'b000, 32'hFFFF_FFFE, 32'd3, cyc, st);
      checks++; if (cyc != MULT_N) begin failures++; $display("FAIL mult_busy_len got=%0d exp=%0d", cyc, MULT_N); end
      checks++; if (!st) begin failures++; $display("FAIL mult_hilo_stable got=changed exp=stable"); end
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
         begin failures++; $display("FAIL mult_neg2x3 got=%h_%h exp=ffffffff_fffffffa", hi, lo); end
      for (int i = 0; i < 6; i++) begin
         op = {2'b00, i[0]};
         a = $urandom; b = (i < 2) ? 32'($urandom_range(0, 50)) : $urandom;
         e = model(op, a, b);
         run_md(op, a, b, cyc, st);
         checks++; if ({hi, lo} !== e || cyc != MULT_N || !st)
            begin failures++; $display("FAIL mult_rand op=%0d a=%h b=%h got=%h_%h/%0d exp=%h/%0d", op, a, b, hi, lo, cyc, e, MULT_N); end
      end
   endtask

   task automatic test_div();
      int cyc; bit st; logic [63:0] e; logic [2:0] op; logic [31:0] a, b;
      run_md(3'b011, 32'd100, 32'd7, cyc, st);
      checks++; if (cyc != DIV_N) begin failures++; $display("FAIL divu_busy_len got=%0d exp=%0d", cyc, DIV_N); end
      checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL divu_100_7 got=%h_%h exp=2_14", hi, lo); end
      run_md(3'b010, 32'hFFFF_FFF9, 32'd2, cyc, st);
      checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
         begin failures++; $display("FAIL div_neg7_2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
      for (int i = 0; i < 8; i++) begin
         op = {2'b01, i[0]};
         a = $urandom;
         b = (i < 4) ? ($urandom_range(1, 1000) * ((i[1]) ? 32'hFFFF_FFFF : 32'd1)) : $urandom;
         e = model(op, a, b);
         run_md(op, a, b, cyc, st);
         checks++; if ({hi, lo} !== e || cyc != DIV_N || !st)
            begin failures++; $display("FAIL div_rand op=%0d a=%h b=%h got=%h_%h/%0d exp=%h/%0d", op, a, b, hi, lo, cyc, e, DIV_N); end
      end
   endtask

   task automatic test_boundaries();
      int cyc; bit st; logic [31:0] a;
      run_md(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc, st);
      checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0)
         begin failures++; $display("FAIL div_overflow got=%h_%h exp=0_80000000", hi, lo); end
      run_md(3'b011, 32'd5, 32'd0, cyc, st);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5)
         begin failures++; $display("FAIL divu_by_zero got=%h_%h exp=5_ffffffff", hi, lo); end
      a = $urandom | 32'h8000_0000;
      run_md(3'b010, a, 32'd0, cyc, st);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== a)
         begin failures++; $display("FAIL div_by_zero got=%h_%h exp=%h_ffffffff", hi, lo, a); end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] l0, h0;
      l0 = lo;
      mt(3'b100, 32'h1234_5678);
      checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0 || lo !== l0)
         begin failures++; $display("FAIL mthi got=%h busy=%0b exp=12345678 busy=0", hi, busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
      h0 = hi;
      mt(3'b101, 32'hCAFE_0001);
      checks++; if (lo !== 32'hCAFE_0001 || hi !== h0 || busy !== 1'b0)
         begin failures++; $display("FAIL mtlo got=%h_%h exp=%h_cafe0001", hi, lo, h0); end
      mt(3'b110, 32'hDEAD_BEEF);
      checks++; if (busy !== 1'b0 || hi !== h0 || lo !== 32'hCAFE_0001)
         begin failures++; $display("FAIL reserved_op got=%h_%h busy=%0b exp=%h_cafe0001 busy=0", hi, lo, busy, h0); end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      logic [63:0] e;
      e = model(3'b000, 32'd1000, 32'hFFFF_FFF0);
      start = 1'b1; md_op = 3'b000; rs_val = 32'd1000; rt_val = 32'hFFFF_FFF0;
      tick();
      md_op = 3'b011; rs_val = 32'd77; rt_val = 32'd3;
      tick();
      start = 1'b0;
      cyc = 1;
      while (busy && cyc < 40) begin cyc++; tick(); end
      checks++; if (cyc != MULT_N) begin failures++; $display("FAIL busy_restart_len got=%0d exp=%0d", cyc, MULT_N); end
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL busy_restart_res got=%h_%h exp=%h", hi, lo, e); end
   endtask

   task automatic test_back_to_back();
      int cyc; bit st; logic [63:0] e;
      run_md(3'b001, 32'd40000, 32'd50000, cyc, st);
      e = model(3'b010, 32'hFFFF_FC00, 32'd9);
      run_md(3'b010, 32'hFFFF_FC00, 32'd9, cyc, st);
      checks++; if ({hi, lo} !== e || cyc != DIV_N)
         begin failures++; $display("FAIL back_to_back got=%h_%h/%0d exp=%h/%0d", hi, lo, cyc, e, DIV_N); end
   endtask

   task automatic test_reset_mid_op();
      int cyc; bit st;
      mt(3'b100, 32'h5555_0000);
      mt(3'b101, 32'h0000_AAAA);
      start = 1'b1; md_op = 3'b010; rs_val = 32'd1000; rt_val = 32'd3;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
         begin failures++; $display("FAIL reset_mid_op got=%0b %h_%h exp=0 0_0", busy, hi, lo); end
      run_md(3'b001, 32'd2, 32'd3, cyc, st);
      checks++; if (lo !== 32'd6 || hi !== 32'd0 || cyc != MULT_N)
         begin failures++; $display("FAIL after_reset_multu got=%h_%h/%0d exp=0_6/%0d", hi, lo, cyc, MULT_N); end
   endtask

`ifdef MD_CANCEL_EN
   task automatic test_cancel();
      mt(3'b101, 32'd9);
      start = 1'b1; md_op = 3'b011; rs_val = 32'd100; rt_val = 32'd10;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      md_cancel = 1'b1;
      tick();
      md_cancel = 1'b0;
      checks++; if (busy !== 1'b0 || lo !== 32'd9) begin failures++; $display("FAIL cancel_run got=%0b lo=%h exp=0 lo=9", busy, lo); end
      start = 1'b1; md_op = 3'b011;
      tick();
      start = 1'b0;
      for (int i = 0; i < DIV_N - 1; i++) tick();
      md_cancel = 1'b1;
      tick();
      md_cancel = 1'b0;
      checks++; if (busy !== 1'b0 || lo !== 32'd9) begin failures++; $display("FAIL cancel_done got=%0b lo=%h exp=0 lo=9", busy, lo); end
      md_cancel = 1'b1;
      mt(3'b101, 32'd123);
      md_cancel = 1'b0;
      checks++; if (busy !== 1'b0 || lo !== 32'd9) begin failures++; $display("FAIL cancel_start got=%0b lo=%h exp=0 lo=9", busy, lo); end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_boundaries();
      test_mthi_mtlo();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
`ifdef MD_CANCEL_EN
      test_cancel();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
